// File: rtl/guitar_pkg.sv
// Shared guitar constants: note bit layout, playback states, tone table.
// Used by the playback engine and the note encoder.
package guitar_pkg;

  localparam int NUM_STRINGS = 6;
  localparam int NUM_FRETS   = 5;
  localparam int HP_W        = 20;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_LATCH = 3'd3;
  localparam state_t S_PLAY  = 3'd4;
  localparam state_t S_FIN   = 3'd5;

  function automatic int idx(input int s, input int f);
    return NUM_STRINGS * f + s;
  endfunction

  // Half-period in 50 MHz clocks, [string][fret], E2 A2 D3 G3 B3 E4.
  localparam logic [0:5][0:4][HP_W-1:0] HALF_PERIOD = '{
    '{20'd303370, 20'd286346, 20'd270273, 20'd255105, 20'd240788},
    '{20'd227273, 20'd214517, 20'd202477, 20'd191113, 20'd180387},
    '{20'd170263, 20'd160707, 20'd151686, 20'd143173, 20'd135137},
    '{20'd127552, 20'd120394, 20'd113636, 20'd107258, 20'd101238},
    '{20'd101238, 20'd95556,  20'd90193,  20'd85131,  20'd80353},
    '{20'd75843,  20'd71586,  20'd67569,  20'd63776,  20'd60197}
  };

endpackage

// File: rtl/tone_gen.sv
// One string's square wave: counts clocks, toggles at the half period.
// Ports: clk, reset, restart (zero phase), fret (0 silent), half table row, tone.
module tone_gen #(
  parameter int TONE_W = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic [2:0]            fret,
  input  logic [0:4][TONE_W-1:0] half,
  output logic                  tone
);

  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic [TONE_W-1:0] half_sel;
  logic              tone_q, tone_d;

  always_comb begin
    half_sel = '0;
    if (fret >= 3'd1 && fret <= 3'd5) begin
      half_sel = half[fret - 3'd1];
    end
  end

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tone_d = tone_q;
    if (restart || fret == 3'd0) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == half_sel - 1'b1) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/note_playback.sv
// Note RAM playback: fetches one note word per tick, decodes per-string frets,
// drives six tone generators. Ports: RAM read side, control, note/tone outputs.
module note_playback
  import guitar_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1,
  parameter int TONE_W   = 20,
  parameter logic [0:5][0:4][TONE_W-1:0] HALF_TAB = HALF_PERIOD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              tick,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [31:0]       rd_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cur_note,
  output logic [17:0]       string_fret,
  output logic              decode_err,
  output logic [5:0]        tone,
  output logic [2:0]        mix_level
);

  localparam int WC_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       note_q, note_d;
  logic [17:0]       fret_q, fret_d;
  logic              err_q, err_d;
  logic              pend_q, pend_d;
  logic [WC_W-1:0]   wait_q, wait_d;
  logic [2:0]        mix_q, mix_d;
  logic [ADDR_W:0]   next_addr;
  logic [2:0]        hits;

  assign next_addr = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    pend_d  = pend_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = S_FIN;
          end else begin
            addr_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (tick) pend_d = 1'b1;
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick) pend_d = 1'b1;
        if (wait_q == WC_W'(READ_LAT - 1)) begin
          state_d = S_LATCH;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (tick) pend_d = 1'b1;
        note_d  = rd_data;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (tick || pend_q) begin
          pend_d = 1'b0;
          if (next_addr == length) begin
            if (loop) begin
              addr_d  = '0;
              state_d = S_FETCH;
            end else begin
              state_d = S_FIN;
            end
          end else begin
            addr_d  = next_addr[ADDR_W-1:0];
            state_d = S_FETCH;
          end
        end
      end
      S_FIN: begin
        note_d  = '0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any tick or start seen this cycle.
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = '0;
      pend_d  = 1'b0;
      wait_d  = '0;
    end
  end

  // Ascending fret scan so the highest set fret is the one kept.
  always_comb begin
    fret_d = '0;
    err_d  = |note_d[31:30];
    hits   = '0;
    for (int s = 0; s < NUM_STRINGS; s++) begin
      hits = '0;
      for (int f = 0; f < NUM_FRETS; f++) begin
        if (note_d[5'(idx(s, f))]) begin
          fret_d[3*s +: 3] = 3'(f + 1);
          hits             = hits + 3'd1;
        end
      end
      if (hits > 3'd1) err_d = 1'b1;
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_STRINGS; i++) begin
      mix_d = mix_d + {2'b00, tone[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      fret_q  <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      wait_q  <= '0;
      mix_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      fret_q  <= fret_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      wait_q  <= wait_d;
      mix_q   <= mix_d;
    end
  end

  // A string restarts its phase whenever its fret changes.
  for (genvar s = 0; s < NUM_STRINGS; s++) begin : g_tone
    tone_gen #(.TONE_W(TONE_W)) u_tone (
      .clk     (clk),
      .reset   (reset),
      .restart (fret_d[3*s +: 3] != fret_q[3*s +: 3]),
      .fret    (fret_q[3*s +: 3]),
      .half    (HALF_TAB[s]),
      .tone    (tone[s])
    );
  end

  assign rd_address  = addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);
  assign cur_note    = note_q;
  assign string_fret = fret_q;
  assign decode_err  = err_q;
  assign mix_level   = mix_q;

endmodule
